// File: rtl/jk_flipflop_bank.sv
// Bank of WIDTH clocked bit-cells with run-time JK / D / T / SR behaviour,
// parallel load, clock enable, change-detect pulse and sticky illegal-SR flag.
module jk_flipflop_bank #(
  parameter int              WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  input  logic             load,
  input  logic [WIDTH-1:0] d_load,
  input  logic             err_clr,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic             changed,
  output logic             err
);

  typedef enum logic [1:0] {
    MODE_JK = 2'b00,
    MODE_D  = 2'b01,
    MODE_T  = 2'b10,
    MODE_SR = 2'b11
  } mode_e;

  logic [WIDTH-1:0] q_next;
  logic             err_set;
  mode_e            mode_sel;

  assign mode_sel = mode_e'(mode);
  assign qb       = ~q;

  // Load beats the enable, which beats the per-bit mode function.
  always_comb begin
    q_next  = q;
    err_set = 1'b0;
    if (load) begin
      q_next = d_load;
    end else if (en) begin
      unique case (mode_sel)
        MODE_JK: q_next = (j & ~q) | (~k & q);
        MODE_D:  q_next = j;
        MODE_T:  q_next = q ^ j;
        MODE_SR: begin
          // S=R=1 is illegal: that bit holds and the sticky flag is raised.
          q_next  = (q | (j & ~k)) & ~(k & ~j);
          err_set = |(j & k);
        end
        default: q_next = q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q       <= RESET_VAL;
      changed <= 1'b0;
      err     <= 1'b0;
    end else begin
      q       <= q_next;
      changed <= (q_next != q);
      if (err_set)
        err <= 1'b1;
      else if (err_clr)
        err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_jk_flipflop_bank.sv
// Directed test-plan steps followed by randomized cycles, checked against a
// per-bit truth-table model of the bank.
module tb_jk_flipflop_bank;

  localparam int              WIDTH = 8;
  localparam logic [WIDTH-1:0] RVAL  = 8'hA5;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             en;
  logic [1:0]       mode;
  logic [WIDTH-1:0] j, k, d_load;
  logic             load, err_clr;
  logic [WIDTH-1:0] q, qb;
  logic             changed, err;

  logic [WIDTH-1:0] exp_q;
  logic             exp_changed, exp_err;
  int               n_checks = 0;
  int               n_pass   = 0;

  jk_flipflop_bank #(.WIDTH(WIDTH), .RESET_VAL(RVAL)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .j(j), .k(k),
    .load(load), .d_load(d_load), .err_clr(err_clr),
    .q(q), .qb(qb), .changed(changed), .err(err)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    exp_q       = RVAL;
    exp_changed = 1'b0;
    exp_err     = 1'b0;
  endtask

  // Behavioural model: each bit follows the mode's truth table.
  task automatic model_edge(input logic m_en, input logic [1:0] m_mode,
                            input logic [WIDTH-1:0] m_j, input logic [WIDTH-1:0] m_k,
                            input logic m_load, input logic [WIDTH-1:0] m_d,
                            input logic m_clr);
    logic [WIDTH-1:0] nq;
    logic             illegal;
    nq      = exp_q;
    illegal = 1'b0;
    if (m_load) begin
      nq = m_d;
    end else if (m_en) begin
      for (int i = 0; i < WIDTH; i++) begin
        case (m_mode)
          2'd0: case ({m_j[i], m_k[i]})
                  2'b01: nq[i] = 1'b0;
                  2'b10: nq[i] = 1'b1;
                  2'b11: nq[i] = ~exp_q[i];
                  default: ;
                endcase
          2'd1: nq[i] = m_j[i];
          2'd2: if (m_j[i]) nq[i] = ~exp_q[i];
          default: case ({m_j[i], m_k[i]})
                  2'b01: nq[i] = 1'b0;
                  2'b10: nq[i] = 1'b1;
                  2'b11: illegal = 1'b1;
                  default: ;
                endcase
        endcase
      end
    end
    if (illegal)      exp_err = 1'b1;
    else if (m_clr)   exp_err = 1'b0;
    exp_changed = (nq != exp_q);
    exp_q       = nq;
  endtask

  task automatic checkOutput(input string tag);
    n_checks++;
    assert (q === exp_q) n_pass++;
    else $error("[TB] FAIL %s q: got %h expected %h", tag, q, exp_q);
    n_checks++;
    assert (qb === ~exp_q) n_pass++;
    else $error("[TB] FAIL %s qb: got %h expected %h", tag, qb, ~exp_q);
    n_checks++;
    assert (changed === exp_changed) n_pass++;
    else $error("[TB] FAIL %s changed: got %b expected %b", tag, changed, exp_changed);
    n_checks++;
    assert (err === exp_err) n_pass++;
    else $error("[TB] FAIL %s err: got %b expected %b", tag, err, exp_err);
  endtask

  task automatic checkValue(input string tag, input logic [WIDTH-1:0] want_q,
                            input logic want_chg, input logic want_err);
    n_checks++;
    assert (q === want_q && changed === want_chg && err === want_err) n_pass++;
    else $error("[TB] FAIL %s q/changed/err: got %h/%b/%b expected %h/%b/%b",
                tag, q, changed, err, want_q, want_chg, want_err);
  endtask

  // Called at a falling edge: drive, advance one rising edge, land on the next falling edge.
  task automatic applyStimulus(input logic s_en, input logic [1:0] s_mode,
                               input logic [WIDTH-1:0] s_j, input logic [WIDTH-1:0] s_k,
                               input logic s_load, input logic [WIDTH-1:0] s_d,
                               input logic s_clr);
    en = s_en; mode = s_mode; j = s_j; k = s_k;
    load = s_load; d_load = s_d; err_clr = s_clr;
    model_edge(s_en, s_mode, s_j, s_k, s_load, s_d, s_clr);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic async_reset_check(input string tag);
    rst_n = 1'b0;
    #2;
    model_reset();
    checkOutput(tag);
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; mode = 2'd0; j = '0; k = '0;
    load = 1'b0; d_load = '0; err_clr = 1'b0;
    model_reset();
    @(negedge clk); @(negedge clk);
    checkOutput("reset");
    checkValue("reset_lit", 8'hA5, 1'b0, 1'b0);
    rst_n = 1'b1;

    applyStimulus(1'b0, 2'd0, 8'h00, 8'h00, 1'b1, 8'h00, 1'b0);
    checkOutput("load00");
    applyStimulus(1'b1, 2'd0, 8'hF0, 8'h0F, 1'b0, 8'h00, 1'b0);
    checkOutput("jk_set_clr");
    checkValue("jk_set_clr_lit", 8'hF0, 1'b1, 1'b0);
    applyStimulus(1'b1, 2'd0, 8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0);
    checkOutput("jk_toggle");
    checkValue("jk_toggle_lit", 8'h0F, 1'b1, 1'b0);
    applyStimulus(1'b1, 2'd0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
    checkOutput("jk_hold");
    checkValue("jk_hold_lit", 8'h0F, 1'b0, 1'b0);

    applyStimulus(1'b1, 2'd1, 8'h3C, 8'hFF, 1'b0, 8'h00, 1'b0);
    checkOutput("d_mode");
    applyStimulus(1'b1, 2'd2, 8'h81, 8'h55, 1'b0, 8'h00, 1'b0);
    checkOutput("t_mode");
    checkValue("t_mode_lit", 8'hBD, 1'b1, 1'b0);
    applyStimulus(1'b0, 2'd2, 8'hFF, 8'h00, 1'b0, 8'h00, 1'b0);
    checkOutput("en_hold");
    checkValue("en_hold_lit", 8'hBD, 1'b0, 1'b0);

    applyStimulus(1'b0, 2'd0, 8'h00, 8'h00, 1'b1, 8'h00, 1'b0);
    checkOutput("load00b");
    applyStimulus(1'b1, 2'd3, 8'h03, 8'h01, 1'b0, 8'h00, 1'b0);
    checkOutput("sr_illegal");
    checkValue("sr_illegal_lit", 8'h02, 1'b1, 1'b1);
    applyStimulus(1'b1, 2'd3, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
    checkOutput("err_sticky");
    applyStimulus(1'b1, 2'd3, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1);
    checkOutput("err_clr");
    checkValue("err_clr_lit", 8'h02, 1'b0, 1'b0);
    applyStimulus(1'b1, 2'd3, 8'h01, 8'h01, 1'b0, 8'h00, 1'b1);
    checkOutput("err_set_wins");
    checkValue("err_set_wins_lit", 8'h02, 1'b0, 1'b1);

    applyStimulus(1'b0, 2'd0, 8'hFF, 8'hFF, 1'b1, 8'h5A, 1'b0);
    checkOutput("load_prio");
    checkValue("load_prio_lit", 8'h5A, 1'b1, 1'b1);
    applyStimulus(1'b1, 2'd3, 8'hFF, 8'hFF, 1'b1, 8'h5A, 1'b0);
    checkOutput("load_same");
    checkValue("load_same_lit", 8'h5A, 1'b0, 1'b1);

    async_reset_check("async_reset");
    checkValue("async_reset_lit", 8'hA5, 1'b0, 1'b0);
    applyStimulus(1'b0, 2'd0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
    checkOutput("post_reset");

    for (int n = 0; n < 300; n++) begin
      applyStimulus(($urandom_range(3) != 0), 2'($urandom_range(3)),
                    8'($urandom), 8'($urandom), ($urandom_range(7) == 0),
                    8'($urandom), ($urandom_range(3) == 0));
      checkOutput("random");
      if (n == 150) async_reset_check("async_reset_rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
